// File: rtl/io_map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_map_pkg
// Description : Bus addresses, CTRL register bit positions and shared helpers
//               for the KEY/SW memory-mapped input responder.
// Revision    : 1.0 - initial release
// ============================================================================
package io_map_pkg;

   localparam logic [31:0] c_addr_key   = 32'hF000_0010;
   localparam logic [31:0] c_addr_kctrl = 32'hF000_0110;
   localparam logic [31:0] c_addr_sw    = 32'hF000_0014;
   localparam logic [31:0] c_addr_sctrl = 32'hF000_0114;

   localparam int c_ready_bit   = 0;
   localparam int c_overrun_bit = 2;
   localparam int c_ie_bit      = 4;

   // Read-mux default; never reaches the bus because rddata is gated by hit.
   localparam logic [31:0] c_unmapped = 32'hDEAD_BEEF;

   // Assemble a CTRL/status word; unused bits read as zero.
   function automatic logic [31:0] ctrl_word(input logic ready,
                                             input logic overrun,
                                             input logic ie);
      logic [31:0] w_word;
      w_word                = '0;
      w_word[c_ready_bit]   = ready;
      w_word[c_overrun_bit] = overrun;
      w_word[c_ie_bit]      = ie;
      return w_word;
   endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
// Module      : io_debounce
// Description : 2-flop synchronizer plus bus-wide debouncer. The debounced
//               value follows the synchronized input once it has differed for
//               DEBOUNCE consecutive cycles; o_chg pulses on that update cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module io_debounce #(
   parameter int WIDTH    = 4,
   parameter int DEBOUNCE = 100000,
   parameter int CNTBITS  = 17
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_db,
   output logic             o_chg
);

   localparam logic [CNTBITS-1:0] c_cnt_last = CNTBITS'(DEBOUNCE - 1);

   logic [WIDTH-1:0]   r_sync1;
   logic [WIDTH-1:0]   r_sync2;
   logic [WIDTH-1:0]   r_db;
   logic [CNTBITS-1:0] r_cnt;
   logic               w_diff;
   logic               w_expire;

   // Bring the asynchronous pins into the clock domain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_din;
         r_sync2 <= r_sync1;
      end
   end

   assign w_diff   = (r_sync2 != r_db);
   assign w_expire = w_diff && (r_cnt == c_cnt_last);

   // Count stable cycles of disagreement; any agreement restarts the window.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_db  <= '0;
         r_cnt <= '0;
      end else if (!w_diff) begin
         r_cnt <= '0;
      end else if (w_expire) begin
         r_db  <= r_sync2;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_db  = r_db;
   assign o_chg = w_expire;

endmodule
`default_nettype wire

// File: rtl/key_sw_io.sv
`default_nettype none
// ============================================================================
// Module      : key_sw_io
// Description : Memory-mapped responder for debounced KEY and SW inputs with
//               per-bus ready/overrun/ie status and a registered interrupt.
//               Read data is combinational for single-cycle loads.
// Revision    : 1.0 - initial release
// ============================================================================
module key_sw_io
   import io_map_pkg::*;
#(
   parameter int               DBITS     = 32,
   parameter logic [DBITS-1:0] ADDRKEY   = c_addr_key,
   parameter logic [DBITS-1:0] ADDRKCTRL = c_addr_kctrl,
   parameter logic [DBITS-1:0] ADDRSW    = c_addr_sw,
   parameter logic [DBITS-1:0] ADDRSCTRL = c_addr_sctrl,
   parameter int               DEBOUNCE  = 100000,
   parameter int               CNTBITS   = 17
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [3:0]       KEY,
   input  logic [9:0]       SW,
   input  logic [DBITS-1:0] addr,
   input  logic [DBITS-1:0] wrdata,
   input  logic             we,
   input  logic             re,
   output logic             hit,
   output logic [DBITS-1:0] rddata,
   output logic             irq
);

   logic [3:0]       w_kdb;
   logic [9:0]       w_sdb;
   logic             w_kchg;
   logic             w_schg;
   logic             w_krd;
   logic             w_srd;
   logic             w_kctrl_wr;
   logic             w_sctrl_wr;
   logic             r_krdy, r_kovr, r_kie;
   logic             r_srdy, r_sovr, r_sie;
   logic             w_krdy_nx, w_kovr_nx, w_kie_nx;
   logic             w_srdy_nx, w_sovr_nx, w_sie_nx;
   logic             r_irq;
   logic [DBITS-1:0] w_mux;
   logic             w_unused_wrdata;

   // Buttons are active-low on the pins; present pressed as 1.
   io_debounce #(
      .WIDTH    (4),
      .DEBOUNCE (DEBOUNCE),
      .CNTBITS  (CNTBITS)
   ) u_key_db (
      .clk     (clk),
      .reset_n (reset_n),
      .i_din   (~KEY),
      .o_db    (w_kdb),
      .o_chg   (w_kchg)
   );

   io_debounce #(
      .WIDTH    (10),
      .DEBOUNCE (DEBOUNCE),
      .CNTBITS  (CNTBITS)
   ) u_sw_db (
      .clk     (clk),
      .reset_n (reset_n),
      .i_din   (SW),
      .o_db    (w_sdb),
      .o_chg   (w_schg)
   );

   assign w_krd      = re && (addr == ADDRKEY);
   assign w_srd      = re && (addr == ADDRSW);
   assign w_kctrl_wr = we && (addr == ADDRKCTRL);
   assign w_sctrl_wr = we && (addr == ADDRSCTRL);

   // Only the overrun and ie bits of a CTRL write carry meaning.
   assign w_unused_wrdata = ^{wrdata[DBITS-1:5], wrdata[3], wrdata[1:0]};

   // Next-state status: a change beats a data read, and an overrun set beats a clear.
   always_comb begin
      w_krdy_nx = r_krdy;
      w_kovr_nx = r_kovr;
      w_kie_nx  = r_kie;
      w_srdy_nx = r_srdy;
      w_sovr_nx = r_sovr;
      w_sie_nx  = r_sie;

      if (w_kchg)     w_krdy_nx = 1'b1;
      else if (w_krd) w_krdy_nx = 1'b0;
      if (w_kctrl_wr) begin
         w_kie_nx = wrdata[c_ie_bit];
         if (!wrdata[c_overrun_bit]) w_kovr_nx = 1'b0;
      end
      if (w_kchg && r_krdy && !w_krd) w_kovr_nx = 1'b1;

      if (w_schg)     w_srdy_nx = 1'b1;
      else if (w_srd) w_srdy_nx = 1'b0;
      if (w_sctrl_wr) begin
         w_sie_nx = wrdata[c_ie_bit];
         if (!wrdata[c_overrun_bit]) w_sovr_nx = 1'b0;
      end
      if (w_schg && r_srdy && !w_srd) w_sovr_nx = 1'b1;
   end

   // Status registers; irq is built from next-state values so it lags the event by one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_krdy <= 1'b0;
         r_kovr <= 1'b0;
         r_kie  <= 1'b0;
         r_srdy <= 1'b0;
         r_sovr <= 1'b0;
         r_sie  <= 1'b0;
         r_irq  <= 1'b0;
      end else begin
         r_krdy <= w_krdy_nx;
         r_kovr <= w_kovr_nx;
         r_kie  <= w_kie_nx;
         r_srdy <= w_srdy_nx;
         r_sovr <= w_sovr_nx;
         r_sie  <= w_sie_nx;
         r_irq  <= (w_krdy_nx & w_kie_nx) | (w_srdy_nx & w_sie_nx);
      end
   end

   assign hit = (addr == ADDRKEY) || (addr == ADDRKCTRL) ||
                (addr == ADDRSW)  || (addr == ADDRSCTRL);

   // Register read mux; the unmapped default is masked off by hit below.
   always_comb begin
      w_mux = DBITS'(c_unmapped);
      case (addr)
         ADDRKEY:   w_mux = {{(DBITS-4){1'b0}}, w_kdb};
         ADDRKCTRL: w_mux = DBITS'(ctrl_word(r_krdy, r_kovr, r_kie));
         ADDRSW:    w_mux = {{(DBITS-10){1'b0}}, w_sdb};
         ADDRSCTRL: w_mux = DBITS'(ctrl_word(r_srdy, r_sovr, r_sie));
         default:   w_mux = DBITS'(c_unmapped);
      endcase
   end

   assign rddata = hit ? w_mux : '0;
   assign irq    = r_irq;

endmodule
`default_nettype wire

// File: doc/key_sw_io.md
Name: key_sw_io

Overview:
- Memory-mapped input responder for the processor data bus.
- Serves the KEY and SW address windows with debounced state plus status/control registers.
- Raises an interrupt request on input change.
- Sits beside data memory and the HEX/LEDR/LEDG output registers; read data returns combinationally in the same cycle as the processor's single-cycle load.

Parameters:
- DBITS, 32, bus data/address width
- ADDRKEY, 32'hF0000010, KEY data register (RO)
- ADDRKCTRL, 32'hF0000110, KEY control/status register
- ADDRSW, 32'hF0000014, SW data register (RO)
- ADDRSCTRL, 32'hF0000114, SW control/status register
- DEBOUNCE, 100000, stable cycles required before a debounced bit updates
- CNTBITS, 17, debounce counter width; must satisfy 2^CNTBITS > DEBOUNCE

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- KEY  in  4  raw pushbuttons, active-low, asynchronous
- SW  in  10  raw switches, asynchronous
- addr  in  DBITS  bus address
- wrdata  in  DBITS  bus write data
- we  in  1  bus write strobe, sampled at posedge clk
- re  in  1  bus read strobe; side effects at posedge clk
- hit  out  1  addr matches one of the four registers (combinational)
- rddata  out  DBITS  read data (combinational); 0 when hit=0
- irq  out  1  (kready&kie)|(sready&sie), registered

Behaviour:
- Reset (reset_n=0, asynchronous): synchronizers, debounced states, counters, ready, overrun, ie and irq all 0. Reset asserted mid-debounce discards the count.
- Input path:
  - KEY is inverted (pressed=1), then 2-flop synchronized.
  - SW is 2-flop synchronized.
  - Each synchronized bus feeds one debouncer.
- Debouncer, per bus (s=synchronized value, db=debounced value, cnt=counter):
  - s==db: cnt<=0.
  - s!=db and cnt==DEBOUNCE-1: db<=s, cnt<=0, pulse chg for one cycle.
  - Otherwise: cnt<=cnt+1.
  - Any return of s to db resets the count, so a bounce restarts the window.
  - Latency: a pin change held stable appears on db 2+DEBOUNCE cycles after first sampling.
- Data registers:
  - KEY data reads {28'b0,kdb}; SW data reads {22'b0,sdb}.
  - Writes to data registers are ignored.
- CTRL register layout: bit0 ready (RO), bit2 overrun (write-0-to-clear; writing 1 has no effect), bit4 ie (RW). All other bits read 0.
- Ready/overrun update, per bus, at posedge, in priority order:
  - chg and ready=1 and no data read: overrun<=1, ready stays 1.
  - chg (any other case): ready<=1.
  - re with addr==data register: ready<=0.
  - chg coinciding with a data read: ready ends 1 and overrun is unchanged. The new change is not lost.
  - A CTRL write with wrdata[2]=0 clears overrun. If chg sets overrun in the same cycle, set wins.
- Bus:
  - hit=1 for exact matches of the four addresses only.
  - we and re asserted together on the same address: both take effect.
  - we/re with hit=0: no state change.
- irq is registered from the next-state ready/ie values, so it is valid the cycle after the causing event.

Decomposition:
- Shared package (io_map_pkg): the four addresses, CTRL bit indices (READY=0, OVERRUN=2, IE=4), and the DEADBEEF unmapped constant used by the top-level bus mux.
- Sub-module io_debounce, parameters WIDTH, DEBOUNCE, CNTBITS, containing the 2-flop synchronizer, counter and chg pulse. key_sw_io instantiates it twice (WIDTH=4 and WIDTH=10).
- Expected RTL size: about 200 lines total.

Test Plan (DEBOUNCE overridden to 4):
- Reset: hold reset_n=0 with SW=10'h3FF -> all reads return 0, irq=0. Release reset -> SW data reads 0x3FF after 6 cycles, SW CTRL reads 0x1.
- Bounce: KEY[0] toggles 0/1/0 with 2-cycle widths, then held 0 -> no chg until 4 stable cycles after the last edge, then KEY data=0x1 and KEY CTRL=0x1.
- Overrun: change SW twice with no read -> SW CTRL=0x5. Read SW data -> SW CTRL=0x4. Write SW CTRL with 0x0 -> reads 0x0.
- Coincidence: a debounced SW change lands in the same cycle as a SW data read -> SW CTRL=0x1 (ready kept, no overrun).
- Interrupt: write 0x10 to KEY CTRL, then press KEY[3] -> irq=1 one cycle after chg, KEY data=0x8. Read KEY data -> irq=0 the following cycle.
- Decode: addr=0xF0000018 with we=1, wrdata=0xFFFFFFFF -> hit=0, rddata=0, no register change. Write 0x1 to KEY data -> value unchanged.
